wb_core_2_master: RTL and testbench

WB_CORE_2_MASTER -- requirements
Module: wb_core_2_master

---
 rtl/wb_core_2_master.sv | 179 +++++++++++++++++
 tb/tb_wb_core_2_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_core_2_master.sv
// Single-outstanding Wishbone pipelined master: command in, one bus cycle, one response out.
// Optional watchdog enabled by defining WB_CORE_2_MASTER_TIMEOUT_EN.
module wb_core_2_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
        $error("wb_core_2_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                  state_r;
    logic                    ready_r;
    logic                    cyc_r;
    logic                    stb_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_dat_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;

    logic                    cmd_fire_s;
    logic                    in_bus_s;
    logic                    done_s;
    logic [DATA_WIDTH-1:0]   rsp_dat_s;
    logic                    expire_s;

    // Ready is also gated by rst_i so it reads 0 for the whole time reset is held.
    assign cmd_ready_o   = ready_r & ~rst_i;
    assign cmd_fire_s    = cmd_valid_i & cmd_ready_o;

    // Completion qualification: slave returns count only while the strobe has been (or is being) accepted.
    always_comb begin
        in_bus_s  = cyc_r & ((state_r == ST_WAIT) | ((state_r == ST_REQ) & ~stall_i));
        done_s    = in_bus_s & (ack_i | err_i);
        if (!we_r && ack_i && !err_i) begin
            rsp_dat_s = dat_i;
        end else begin
            rsp_dat_s = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef WB_CORE_2_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);
    logic [15:0] wdog_r;

    // Watchdog: counts cycles spent in REQ/WAIT since the command was launched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_r <= 16'd0;
        end else if (cmd_fire_s) begin
            wdog_r <= 16'd0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            wdog_r <= wdog_r + 16'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign expire_s = ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                      (wdog_r == (TIMEOUT_L - 16'd1));
`else
    assign expire_s = 1'b0;
`endif

    // Main transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_IDLE;
            ready_r       <= 1'b1;
            cyc_r         <= 1'b0;
            stb_r         <= 1'b0;
            we_r          <= 1'b0;
            adr_r         <= {ADDR_WIDTH{1'b0}};
            dat_r         <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_dat_r     <= {DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        state_r <= ST_REQ;
                        ready_r <= 1'b0;
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        we_r    <= cmd_we_i;
                        adr_r   <= cmd_adr_i;
                        dat_r   <= cmd_dat_i;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    // A real ack/err beats a watchdog expiry landing in the same cycle.
                    if (done_s) begin
                        state_r       <= ST_RESP;
                        cyc_r         <= 1'b0;
                        stb_r         <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_dat_r     <= rsp_dat_s;
                        rsp_err_r     <= err_i;
                        rsp_timeout_r <= 1'b0;
                    end else if (expire_s) begin
                        state_r       <= ST_RESP;
                        cyc_r         <= 1'b0;
                        stb_r         <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        rsp_dat_r     <= {DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                    end else if ((state_r == ST_REQ) && !stall_i) begin
                        state_r <= ST_WAIT;
                        stb_r   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_r       <= ST_IDLE;
                        ready_r       <= 1'b1;
                        rsp_valid_r   <= 1'b0;
                        rsp_dat_r     <= {DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b0;
                        rsp_timeout_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    cyc_r       <= 1'b0;
                    stb_r       <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cyc_o         = cyc_r;
    assign stb_o         = stb_r;
    assign we_o          = we_r;
    assign adr_o         = adr_r;
    assign dat_o         = dat_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_dat_o     = rsp_dat_r;
    assign rsp_err_o     = rsp_err_r;
    assign rsp_timeout_o = rsp_timeout_r;

endmodule

// File: tb/tb_wb_core_2_master.sv
// Scoreboard bench for wb_core_2_master: stimulus pushes expected responses, a negedge monitor pops them.
module tb_wb_core_2_master;

`ifdef WB_CORE_2_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [15:0] cmd_adr_i = 16'h0;
    logic [31:0] cmd_dat_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        stall_i = 1'b0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    wb_core_2_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a command; returns positioned in the first REQ cycle.
    task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat);
        int n = 0;
        while (!cmd_ready_o && n < 10) begin
            tick();
            n++;
        end
        check("issue_ready", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = dat;
        tick();
        cmd_valid_i = 1'b0;
        check("req_stb", {31'd0, stb_o}, 32'd1);
        check("req_cyc", {31'd0, cyc_o}, 32'd1);
        check("req_adr", {16'd0, adr_o}, {16'd0, adr});
        check("req_we", {31'd0, we_o}, {31'd0, we});
        if (we) check("req_dat", dat_o, dat);
    endtask

    // Response monitor: compares every response handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got dat %h err %b expected no response", rsp_dat_o, rsp_err_o);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_dat", rsp_dat_o, e.dat);
                check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
                check("rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, e.tmo});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset values
        tick(); tick(); tick();
        check("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        check("rst_cyc", {31'd0, cyc_o}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_adr", {16'd0, adr_o}, 32'd0);
        check("rst_rspdat", rsp_dat_o, 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Write, ack one cycle after the strobe
        sb_q.push_back('{dat: 32'h0, err: 1'b0, tmo: 1'b0});
        issue(1'b1, 16'h0004, 32'hDEADBEEF);
        tick();
        check("wr_wait_stb", {31'd0, stb_o}, 32'd0);
        check("wr_wait_cyc", {31'd0, cyc_o}, 32'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("wr_rsp_cyc", {31'd0, cyc_o}, 32'd0);
        tick();

        // Zero-wait read: ack alongside the strobe gives a response the next cycle
        sb_q.push_back('{dat: 32'hA5A50F0F, err: 1'b0, tmo: 1'b0});
        issue(1'b0, 16'h0010, 32'h0);
        ack_i = 1'b1; dat_i = 32'hA5A50F0F;
        tick();
        ack_i = 1'b0; dat_i = 32'h0;
        check("lat_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        tick();

        // Read with 3 stall cycles: strobe and address held for 4 cycles
        sb_q.push_back('{dat: 32'h12345678, err: 1'b0, tmo: 1'b0});
        issue(1'b0, 16'h0008, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("stall_stb", {31'd0, stb_o}, 32'd1);
            check("stall_adr", {16'd0, adr_o}, 32'h0008);
            stall_i = (i < 3);
            ack_i   = (i == 3);
            dat_i   = 32'h12345678;
            tick();
        end
        stall_i = 1'b0; ack_i = 1'b0; dat_i = 32'h0;
        check("stall_done_stb", {31'd0, stb_o}, 32'd0);
        check("stall_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        tick();

        // ack and err together count as an error
        sb_q.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b0});
        issue(1'b0, 16'h0020, 32'h0);
        ack_i = 1'b1; err_i = 1'b1; dat_i = 32'hFFFFFFFF;
        tick();
        ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h0;
        tick();

        // Response back-pressure: fields stable, commands ignored
        rsp_ready_i = 1'b0;
        sb_q.push_back('{dat: 32'hCAFEF00D, err: 1'b0, tmo: 1'b0});
        issue(1'b0, 16'h0030, 32'h0);
        tick();
        ack_i = 1'b1; dat_i = 32'hCAFEF00D;
        tick();
        ack_i = 1'b0; dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 16'h0099; cmd_dat_i = 32'h11111111;
            check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("bp_dat", rsp_dat_o, 32'hCAFEF00D);
            check("bp_err", {31'd0, rsp_err_o}, 32'd0);
            check("bp_ready", {31'd0, cmd_ready_o}, 32'd0);
            check("bp_cyc", {31'd0, cyc_o}, 32'd0);
            tick();
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        check("bp_idle_ready", {31'd0, cmd_ready_o}, 32'd1);
        check("bp_idle_cyc", {31'd0, cyc_o}, 32'd0);
        check("bp_idle_valid", {31'd0, rsp_valid_o}, 32'd0);

        // Reset two cycles into WAIT abandons the transaction
        issue(1'b0, 16'h0040, 32'h0);
        tick();
        tick();
        check("mid_wait_cyc", {31'd0, cyc_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
        check("mid_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        rst_i = 1'b0;
        ack_i = 1'b1; dat_i = 32'h55AA55AA;
        #1;
        check("mid_rel_ready", {31'd0, cmd_ready_o}, 32'd1);
        tick();
        ack_i = 1'b0; dat_i = 32'h0;
        check("mid_late_ack_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("mid_late_ack_cyc", {31'd0, cyc_o}, 32'd0);

`ifdef WB_CORE_2_MASTER_TIMEOUT_EN
        // Watchdog: slave never responds
        begin
            int n = 0;
            sb_q.push_back('{dat: 32'h0, err: 1'b1, tmo: 1'b1});
            issue(1'b1, 16'h0050, 32'h0BADF00D);
            while (cyc_o && n < 40) begin
                n++;
                tick();
            end
            check("tmo_cycles", n, 32'd8);
            check("tmo_valid", {31'd0, rsp_valid_o}, 32'd1);
            tick();
        end
`else
        check("tmo_const", {31'd0, rsp_timeout_o}, 32'd0);
`endif

        tick(); tick();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
